// File: rtl/dmux_8bits_buf.sv
// Registered 1-to-4 demultiplexer: one input stream is steered by sel1/sel2/sel3
// into one of four single-entry output buffers, each with its own valid/ready sink.
module dmux_8bits_buf #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            sel1,
  input  logic            sel2,
  input  logic            sel3,
  output logic [SIZE-1:0] a,
  output logic [SIZE-1:0] b,
  output logic [SIZE-1:0] c,
  output logic [SIZE-1:0] d,
  output logic            a_valid,
  output logic            b_valid,
  output logic            c_valid,
  output logic            d_valid,
  input  logic            a_ready,
  input  logic            b_ready,
  input  logic            c_ready,
  input  logic            d_ready
);

  // Channel index: 0=a, 1=b, 2=c, 3=d
  logic [1:0]      tgt;
  logic [3:0]      ready_vec;
  logic [3:0]      valid_q;
  logic [3:0]      valid_d;
  logic [3:0]      load;
  logic [SIZE-1:0] data_q [4];
  logic [SIZE-1:0] data_d [4];
  logic            accept;

  assign ready_vec = {d_ready, c_ready, b_ready, a_ready};

  always_comb begin
    tgt = 2'd0;
    if (sel3) begin
      tgt = sel1 ? 2'd0 : 2'd1;
    end else begin
      tgt = sel2 ? 2'd2 : 2'd3;
    end
  end

  // Only the selected buffer gates the input; a full buffer may still accept
  // when its sink drains in the same cycle.
  assign in_ready = ~valid_q[tgt] | ready_vec[tgt];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign load[gi]    = accept & (tgt == gi[1:0]);
      assign valid_d[gi] = load[gi] | (valid_q[gi] & ~ready_vec[gi]);
      assign data_d[gi]  = load[gi] ? in : data_q[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  assign a       = data_q[0];
  assign b       = data_q[1];
  assign c       = data_q[2];
  assign d       = data_q[3];
  assign a_valid = valid_q[0];
  assign b_valid = valid_q[1];
  assign c_valid = valid_q[2];
  assign d_valid = valid_q[3];

endmodule

// File: tb/tb_dmux_8bits_buf.sv
// Bench for dmux_8bits_buf: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural buffer model.
module tb_dmux_8bits_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic       sel1, sel2, sel3;
  logic [7:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic [3:0] rdy;

  int vectors     = 0;
  int miscompares = 0;

  dmux_8bits_buf #(.SIZE(8)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(rdy[0]), .b_ready(rdy[1]), .c_ready(rdy[2]), .d_ready(rdy[3])
  );

  always #5 clk = ~clk;

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: four one-word buffers, each either holding a word or empty.
  logic       m_full [4];
  logic [7:0] m_word [4];

  function automatic int route(logic s1, logic s2, logic s3);
    if (s3) return s1 ? 0 : 1;
    return s2 ? 2 : 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] <= 1'b0;
        m_word[i] <= 8'h00;
      end
    end else begin
      automatic int  t    = route(sel1, sel2, sel3);
      automatic bit  take = in_valid && (!m_full[t] || rdy[t]);
      for (int i = 0; i < 4; i++) begin
        if (take && t == i) begin
          m_word[i] <= din;
          m_full[i] <= 1'b1;
        end else if (m_full[i] && rdy[i]) begin
          m_full[i] <= 1'b0;
        end
      end
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      automatic int t = route(sel1, sel2, sel3);
      chk1("m_in_ready", in_ready, !m_full[t] || rdy[t]);
      chk1("m_a_valid", a_valid, m_full[0]);
      chk1("m_b_valid", b_valid, m_full[1]);
      chk1("m_c_valid", c_valid, m_full[2]);
      chk1("m_d_valid", d_valid, m_full[3]);
      chk8("m_a", a, m_word[0]);
      chk8("m_b", b, m_word[1]);
      chk8("m_c", c, m_word[2]);
      chk8("m_d", d, m_word[3]);
    end
  end

  task automatic chk_valids(string name, logic [3:0] exp);
    chk8(name, {4'h0, d_valid, c_valid, b_valid, a_valid}, {4'h0, exp});
  endtask

  task automatic load_word(logic s1, logic s2, logic s3, logic [7:0] w);
    sel1 = s1; sel2 = s2; sel3 = s3; din = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00; in_valid = 1'b0; sel1 = 1'b0; sel2 = 1'b0; sel3 = 1'b0; rdy = 4'h0;
    tick();
    tick();
    chk_valids("reset_valids", 4'b0000);
    chk8("reset_a", a, 8'h00);
    chk8("reset_d", d, 8'h00);
    rst = 1'b0;

    // Single word to a, sink stalled
    sel3 = 1'b1; sel1 = 1'b1; din = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    chk1("t2_in_ready_empty", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk8("t2_a", a, 8'hA5);
    chk_valids("t2_valids", 4'b0001);
    chk1("t2_in_ready_full", in_ready, 1'b0);

    // Stalled word retargeted from a to b
    tick();
    din = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    chk1("t5_blocked", in_ready, 1'b0);
    tick();
    chk8("t5_a_held", a, 8'hA5);
    sel1 = 1'b0;
    #1;
    chk1("t5_retarget_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk8("t5_b", b, 8'h5A);
    chk8("t5_a_still", a, 8'hA5);
    chk_valids("t5_valids", 4'b0011);
    rdy = 4'hF;
    tick();
    rdy = 4'h0;
    @(negedge clk);
    chk_valids("drain_all", 4'b0000);

    // Full-throughput stream to d
    tick();
    sel3 = 1'b0; sel2 = 1'b0; rdy[3] = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din = 8'(k);
      tick();
      @(negedge clk);
      chk8("t3_d", d, 8'(k));
      chk1("t3_d_valid", d_valid, 1'b1);
      chk1("t3_in_ready", in_ready, 1'b1);
      #4;
    end
    in_valid = 1'b0;
    tick();
    rdy = 4'h0;

    // Independent drain: a drains while c stays stalled
    load_word(1'b1, 1'b0, 1'b1, 8'h11);
    load_word(1'b0, 1'b1, 1'b0, 8'h22);
    @(negedge clk);
    chk8("t4_c", c, 8'h22);
    chk8("t4_a", a, 8'h11);
    chk_valids("t4_valids", 4'b0101);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    @(negedge clk);
    chk_valids("t4_after_drain", 4'b0100);
    chk8("t4_a_kept", a, 8'h11);

    // Asynchronous reset mid-stream with a and c full
    tick();
    load_word(1'b1, 1'b0, 1'b1, 8'h77);
    @(negedge clk);
    chk_valids("t1_before", 4'b0101);
    #2;
    rst = 1'b1;
    #1;
    chk_valids("t1_async_valids", 4'b0000);
    chk8("t1_async_a", a, 8'h00);
    chk8("t1_async_c", c, 8'h00);
    tick();
    rst = 1'b0;

    // All four full, all drained in one cycle
    load_word(1'b1, 1'b0, 1'b1, 8'h11);
    load_word(1'b0, 1'b0, 1'b1, 8'h22);
    load_word(1'b0, 1'b1, 1'b0, 8'h33);
    load_word(1'b0, 1'b0, 1'b0, 8'h44);
    @(negedge clk);
    chk_valids("t6_full", 4'b1111);
    rdy = 4'hF;
    tick();
    rdy = 4'h0;
    @(negedge clk);
    chk_valids("t6_drained", 4'b0000);
    chk8("t6_a", a, 8'h11);
    chk8("t6_b", b, 8'h22);
    chk8("t6_c", c, 8'h33);
    chk8("t6_d", d, 8'h44);

    // Randomized traffic, checked by the model on every cycle
    tick();
    for (int n = 0; n < 2000; n++) begin
      din      = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      sel1     = 1'($urandom);
      sel2     = 1'($urandom);
      sel3     = 1'($urandom);
      rdy      = 4'($urandom);
      if (n % 500 == 250) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
